pseudo_rev: RTL and testbench

- Reverse stepper for the team's 8-bit Fibonacci LFSR generator (pseudo).
- Given an observed output value and the number of steps that produced it, `pseudo_rev` runs the LFSR backwards one step per clock and recovers the original seed.
- Used in the board-level self-check path and for seed recovery from captured sequences.
- Same start/busy handshake style as the generator, plus a one-cycle done pulse.

---
 rtl/pseudo_pkg.sv | 25 ++
 rtl/pseudo_edge.sv | 22 ++
 rtl/pseudo_rev.sv | 97 +++++++++
 tb/tb_pseudo_rev.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pseudo_pkg.sv
// Shared definitions for the 8-bit Fibonacci LFSR generator (pseudo) and its
// reverse stepper (pseudo_rev): width, tap mask, FSM states and step functions.
package pseudo_pkg;

  localparam int LFSR_W = 8;

  // Taps at bits 7,5,4,3: x^8+x^6+x^5+x^4+1, maximal length 255.
  localparam logic [LFSR_W-1:0] TAPS = 8'hB8;

  typedef enum logic {
    IDLE = 1'b0,
    STEP = 1'b1
  } pseudo_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_fwd(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & TAPS)};
  endfunction

  // Undo one forward step: the new LSB was the feedback bit, so the lost MSB
  // is that bit XORed with the other taps, which now sit one position higher.
  function automatic logic [LFSR_W-1:0] lfsr_rev(input logic [LFSR_W-1:0] q);
    return {q[0] ^ (^(q[LFSR_W-1:1] & TAPS[LFSR_W-2:0])), q[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/pseudo_edge.sv
// Rising-edge detector whose history resets to 1, so a level already high
// when reset is released is not reported as an edge.
module pseudo_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b1;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/pseudo_rev.sv
// Reverse stepper for the pseudo LFSR: unwinds num_in by seq_num steps, one per
// clock, to recover the seed. Optional seed compare: define PSEUDO_REV_MATCH_EN.
module pseudo_rev
  import pseudo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] num_in,
  input  logic [CNT_W-1:0] seq_num,
`ifdef PSEUDO_REV_MATCH_EN
  input  logic [WIDTH-1:0] exp_seed,
  output logic             match,
`endif
  output logic [WIDTH-1:0] seed,
  output logic             busy,
  output logic             done,
  output logic             zero_err
);

  pseudo_state_e    fsm;
  logic [WIDTH-1:0] state_reg;
  logic [CNT_W-1:0] cnt;
  logic             start_rise;
  logic             launch;

  pseudo_edge u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (start),
    .rise (start_rise)
  );

  // The done cycle is already IDLE, so it is excluded explicitly: edges there are dropped.
  assign launch = start_rise && (fsm == IDLE) && !done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state_reg <= '0;
      cnt       <= '0;
      seed      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      zero_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (launch) begin
            state_reg <= num_in;
            cnt       <= seq_num;
            zero_err  <= (num_in == '0);
            busy      <= 1'b1;
            fsm       <= STEP;
          end
        end
        STEP: begin
          if (cnt != '0) begin
            state_reg <= lfsr_rev(state_reg);
            cnt       <= cnt - CNT_W'(1);
          end else begin
            seed <= state_reg;
            done <= 1'b1;
            busy <= 1'b0;
            fsm  <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

`ifdef PSEUDO_REV_MATCH_EN
  logic [WIDTH-1:0] exp_q;

  // Compare is evaluated on the same edge that publishes seed, so match and
  // seed always describe the same completed operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
      match <= 1'b0;
    end else begin
      if (launch) begin
        exp_q <= exp_seed;
      end
      if (fsm == STEP && cnt == '0) begin
        match <= (state_reg == exp_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pseudo_rev.sv
// Self-checking bench for pseudo_rev: directed vector table, random round trips
// through an independent forward model, and hand-written handshake/reset cases.
module tb_pseudo_rev;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] num_in;
  logic [7:0] seq_num;
  logic [7:0] seed;
  logic       busy;
  logic       done;
  logic       zero_err;
`ifdef PSEUDO_REV_MATCH_EN
  logic [7:0] exp_seed;
  logic       match;
`endif

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  pseudo_rev #(.WIDTH(8), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .num_in  (num_in),
    .seq_num (seq_num),
`ifdef PSEUDO_REV_MATCH_EN
    .exp_seed(exp_seed),
    .match   (match),
`endif
    .seed    (seed),
    .busy    (busy),
    .done    (done),
    .zero_err(zero_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n === 1'b1 && done === 1'b1) done_cnt++;

  typedef struct {
    string      name;
    logic [7:0] num;
    logic [7:0] sn;
    logic [7:0] exp_s;
    logic [7:0] want_seed;
    logic       want_zero;
    logic       want_match;
  } vec_t;

  vec_t vecs[7];

  // Written out bit by bit from the generator's feedback equation.
  function automatic logic [7:0] fwd_model(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // Launch one operation from a negedge and return at the negedge where busy fell.
  task automatic apply_stimulus(input logic [7:0] num, input logic [7:0] sn,
                                input logic [7:0] es, output int bcyc, output bit ok);
    @(negedge clk);
    num_in  = num;
    seq_num = sn;
`ifdef PSEUDO_REV_MATCH_EN
    exp_seed = es;
`else
    if (es == 8'h00) bcyc = 0;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcyc = 0;
    while (busy === 1'b1 && bcyc < 300) begin
      bcyc++;
      @(negedge clk);
    end
    ok = (busy === 1'b0);
  endtask

  task automatic check_output(input string name, input vec_t v, input int bcyc, input bit ok);
    check({name, " finished"}, 32'(ok), 32'd1);
    check({name, " busy cycles"}, 32'(bcyc), 32'(v.sn) + 32'd1);
    check({name, " done"}, 32'(done), 32'd1);
    check({name, " seed"}, 32'(seed), 32'(v.want_seed));
    check({name, " zero_err"}, 32'(zero_err), 32'(v.want_zero));
`ifdef PSEUDO_REV_MATCH_EN
    check({name, " match"}, 32'(match), 32'(v.want_match));
`else
    if (v.want_match === 1'bx) checks = checks;
`endif
    @(negedge clk);
    check({name, " done pulse width"}, 32'(done), 32'd0);
    check({name, " zero_err sticky"}, 32'(zero_err), 32'(v.want_zero));
  endtask

  initial begin
    int   bcyc;
    bit   ok;
    int   base;
    logic saw_busy;
    logic [7:0] orig;
    logic [7:0] obs;
    logic [7:0] sn;
    vec_t v;

    vecs[0] = '{"c4_9",     8'hC4, 8'd9,   8'h08, 8'h08, 1'b0, 1'b1};
    vecs[1] = '{"c4_9_mis", 8'hC4, 8'd9,   8'h09, 8'h08, 1'b0, 1'b0};
    vecs[2] = '{"02_1",     8'h02, 8'd1,   8'h01, 8'h01, 1'b0, 1'b1};
    vecs[3] = '{"5a_0",     8'h5A, 8'd0,   8'h5A, 8'h5A, 1'b0, 1'b1};
    vecs[4] = '{"zero_5",   8'h00, 8'd5,   8'h00, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{"01_0",     8'h01, 8'd0,   8'h00, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{"ff_3",     8'hFF, 8'd3,   8'h9F, 8'h9F, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; num_in = 8'h00; seq_num = 8'h00;
`ifdef PSEUDO_REV_MATCH_EN
    exp_seed = 8'h00;
`endif
    repeat (3) @(negedge clk);
    check("reset seed", 32'(seed), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset zero_err", 32'(zero_err), 32'd0);
`ifdef PSEUDO_REV_MATCH_EN
    check("reset match", 32'(match), 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i].num, vecs[i].sn, vecs[i].exp_s, bcyc, ok);
      check_output(vecs[i].name, vecs[i], bcyc, ok);
    end

    // Round trips: wind a known seed forward with the model, then unwind it.
    for (int i = 0; i < 16; i++) begin
      orig = 8'($urandom_range(1, 255));
      sn   = (i == 0) ? 8'd0 : (i == 1) ? 8'd255 : 8'($urandom_range(0, 255));
      obs  = orig;
      for (int k = 0; k < int'(sn); k++) obs = fwd_model(obs);
      if (i == 1) check("period 255 model", 32'(obs), 32'(orig));
      v = '{"roundtrip", obs, sn, orig, orig, 1'b0, 1'b1};
      apply_stimulus(obs, sn, orig, bcyc, ok);
      check_output("roundtrip", v, bcyc, ok);
    end

    // Extra edges and input changes while busy, then start held past done.
    base = done_cnt;
    @(negedge clk);
    num_in = 8'hC4; seq_num = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    num_in = 8'hFF; seq_num = 8'd3; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    bcyc = 0;
    while (busy === 1'b1 && bcyc < 300) begin bcyc++; @(negedge clk); end
    check("busy edges seed", 32'(seed), 32'h08);
    check("busy edges done", 32'(done), 32'd1);
    saw_busy = 1'b0;
    repeat (10) begin @(negedge clk); if (busy !== 1'b0) saw_busy = 1'b1; end
    check("held start relaunch", 32'(saw_busy), 32'd0);
    check("held start done count", 32'(done_cnt - base), 32'd1);
    check("seed holds", 32'(seed), 32'h08);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcyc = 0;
    while (busy === 1'b1 && bcyc < 300) begin bcyc++; @(negedge clk); end
    check("second edge seed", 32'(seed), 32'h9F);
    check("second edge busy cycles", 32'(bcyc), 32'd4);
    @(negedge clk);
    check("second edge done count", 32'(done_cnt - base), 32'd2);

    // An edge that arrives in the done cycle is dropped, not queued.
    num_in = 8'h02; seq_num = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcyc = 0;
    while (busy === 1'b1 && bcyc < 300) begin bcyc++; @(negedge clk); end
    check("done-cycle edge done", 32'(done), 32'd1);
    start = 1'b1;
    saw_busy = 1'b0;
    repeat (5) begin @(negedge clk); if (busy !== 1'b0) saw_busy = 1'b1; end
    check("done-cycle edge ignored", 32'(saw_busy), 32'd0);
    start = 1'b0;

    // Reset in the middle of a run, with start held high across release.
    @(negedge clk);
    num_in = 8'h00; seq_num = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    check("pre-reset zero_err", 32'(zero_err), 32'd1);
    base = done_cnt;
    #2 rst_n = 1'b0;
    start = 1'b1;
    #1;
    check("midrun reset seed", 32'(seed), 32'd0);
    check("midrun reset busy", 32'(busy), 32'd0);
    check("midrun reset zero_err", 32'(zero_err), 32'd0);
    check("midrun reset done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_busy = 1'b0;
    repeat (14) begin @(negedge clk); if (busy !== 1'b0) saw_busy = 1'b1; end
    check("no launch after reset", 32'(saw_busy), 32'd0);
    check("no done after reset", 32'(done_cnt - base), 32'd0);
    start = 1'b0;

    apply_stimulus(8'hC4, 8'd9, 8'h08, bcyc, ok);
    check_output("after reset", vecs[0], bcyc, ok);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
